// File: rtl/cpu_log_emitter_pkg.sv
// Shared definitions for the CPU trace character emitter: ASCII symbols,
// state encoding, record-length constants and nibble-select helpers.
package cpu_log_emitter_pkg;

   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_AT     = 8'h40;
   localparam logic [7:0] CH_COLON  = 8'h3A;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_LT     = 8'h3C;
   localparam logic [7:0] CH_EQ     = 8'h3D;
   localparam logic [7:0] CH_HASH   = 8'h23;
   localparam logic [7:0] CH_QMARK  = 8'h3F;

   // Register record = REC_LEN_REG_BASE + time digits + register digits;
   // memory record = REC_LEN_MEM_BASE + time digits.
   localparam int REC_LEN_REG_BASE = 26;
   localparam int REC_LEN_MEM_BASE = 34;

   typedef enum logic [3:0] {
      ST_IDLE, ST_CARET, ST_TIME, ST_AT, ST_PC, ST_COLON, ST_SP1, ST_KIND,
      ST_TARGET, ST_SP2, ST_LT, ST_EQ, ST_SP3, ST_DATA, ST_HASH
   } state_e;

   // Digit index 0 selects the most significant nibble.
   function automatic logic [3:0] hex_nibble(input logic [31:0] word, input logic [2:0] idx);
      return word[{~idx, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] bcd_nibble(input logic [15:0] t, input logic [1:0] idx);
      return t[{~idx, 2'b00} +: 4];
   endfunction

   // First digit to print when leading zeros are suppressed; time 0 still prints "0".
   function automatic logic [1:0] time_first_digit(input logic [15:0] t);
      if (t[15:12] != 4'h0)     return 2'd0;
      else if (t[11:8] != 4'h0) return 2'd1;
      else if (t[7:4] != 4'h0)  return 2'd2;
      else                      return 2'd3;
   endfunction

endpackage

// File: rtl/cpu_log_emitter_nibble_to_ascii.sv
// Converts one 4-bit value to its ASCII digit, either as hex or as BCD
// (an out-of-range BCD nibble becomes '?').
module nibble_to_ascii
   import cpu_log_emitter_pkg::*;
#(
   parameter logic HEX_UPPER = 1'b0
) (
   input  logic [3:0] nibble,
   input  logic       bcd_mode,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = 8'h30 + {4'h0, nibble};
      if (nibble > 4'd9) begin
         if (bcd_mode)
            ascii = CH_QMARK;
         else
            ascii = (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, nibble};
      end
   end

endmodule

// File: rtl/cpu_log_emitter.sv
// Serialises one captured CPU trace record as an ASCII character stream,
// one character per clock, framed by '^' ... '#'.
module cpu_log_emitter
   import cpu_log_emitter_pkg::*;
#(
   parameter logic       HEX_UPPER = 1'b0,
   parameter logic [7:0] IDLE_CHAR = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_mem,
   input  logic [15:0] in_time,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_reg,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   output logic [7:0]  char_out,
   output logic        char_valid,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic        is_mem_q, is_mem_d;
   logic [15:0] time_q, time_d;
   logic [31:0] pc_q, pc_d;
   logic [4:0]  reg_q, reg_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;

   logic        hs;
   logic [3:0]  reg_tens, reg_ones;
   logic        reg_two_digits;
   logic [3:0]  digit_nib;
   logic        digit_bcd;
   logic [7:0]  digit_ascii;

   assign in_ready   = reset & ((state_q == ST_IDLE) | (state_q == ST_HASH));
   assign hs         = in_valid & in_ready;
   assign busy       = (state_q != ST_IDLE);
   assign char_valid = (state_q != ST_IDLE);

   // Decimal register number by range compare and subtraction.
   assign reg_two_digits = (reg_q >= 5'd10);
   always_comb begin
      reg_tens = 4'd0;
      reg_ones = reg_q[3:0];
      if (reg_q >= 5'd30) begin
         reg_tens = 4'd3;
         reg_ones = 4'(reg_q - 5'd30);
      end else if (reg_q >= 5'd20) begin
         reg_tens = 4'd2;
         reg_ones = 4'(reg_q - 5'd20);
      end else if (reg_q >= 5'd10) begin
         reg_tens = 4'd1;
         reg_ones = 4'(reg_q - 5'd10);
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      is_mem_d = is_mem_q;
      time_d   = time_q;
      pc_d     = pc_q;
      reg_d    = reg_q;
      addr_d   = addr_q;
      data_d   = data_q;

      if (hs) begin
         is_mem_d = in_is_mem;
         time_d   = in_time;
         pc_d     = in_pc;
         reg_d    = in_reg;
         addr_d   = in_addr;
         data_d   = in_data;
      end

      case (state_q)
         ST_IDLE:   if (hs) state_d = ST_CARET;
         ST_CARET: begin
            state_d = ST_TIME;
            idx_d   = {2'b00, time_first_digit(time_q)};
         end
         ST_TIME: begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd3) state_d = ST_AT;
         end
         ST_AT: begin
            state_d = ST_PC;
            idx_d   = 4'd0;
         end
         ST_PC: begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd7) state_d = ST_COLON;
         end
         ST_COLON:  state_d = ST_SP1;
         ST_SP1:    state_d = ST_KIND;
         ST_KIND: begin
            state_d = ST_TARGET;
            // Single-digit register numbers skip the tens position.
            idx_d   = (is_mem_q || reg_two_digits) ? 4'd0 : 4'd1;
         end
         ST_TARGET: begin
            idx_d = idx_q + 4'd1;
            if (is_mem_q ? (idx_q == 4'd7) : (idx_q == 4'd1)) state_d = ST_SP2;
         end
         ST_SP2:    state_d = ST_LT;
         ST_LT:     state_d = ST_EQ;
         ST_EQ:     state_d = ST_SP3;
         ST_SP3: begin
            state_d = ST_DATA;
            idx_d   = 4'd0;
         end
         ST_DATA: begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd7) state_d = ST_HASH;
         end
         ST_HASH:   state_d = hs ? ST_CARET : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      digit_nib = 4'h0;
      digit_bcd = 1'b0;
      case (state_q)
         ST_TIME: begin
            digit_nib = bcd_nibble(time_q, idx_q[1:0]);
            digit_bcd = 1'b1;
         end
         ST_PC:   digit_nib = hex_nibble(pc_q, idx_q[2:0]);
         ST_TARGET: begin
            if (is_mem_q) begin
               digit_nib = hex_nibble(addr_q, idx_q[2:0]);
            end else begin
               digit_nib = (idx_q == 4'd0) ? reg_tens : reg_ones;
               digit_bcd = 1'b1;
            end
         end
         ST_DATA: digit_nib = hex_nibble(data_q, idx_q[2:0]);
         default: digit_nib = 4'h0;
      endcase
   end

   nibble_to_ascii #(.HEX_UPPER(HEX_UPPER)) u_digit (
      .nibble   (digit_nib),
      .bcd_mode (digit_bcd),
      .ascii    (digit_ascii)
   );

   always_comb begin
      char_out = IDLE_CHAR;
      case (state_q)
         ST_CARET:                         char_out = CH_CARET;
         ST_TIME, ST_PC, ST_TARGET, ST_DATA: char_out = digit_ascii;
         ST_AT:                            char_out = CH_AT;
         ST_COLON:                         char_out = CH_COLON;
         ST_SP1, ST_SP2, ST_SP3:           char_out = CH_SPACE;
         ST_KIND:                          char_out = is_mem_q ? CH_STAR : CH_DOLLAR;
         ST_LT:                            char_out = CH_LT;
         ST_EQ:                            char_out = CH_EQ;
         ST_HASH:                          char_out = CH_HASH;
         default:                          char_out = IDLE_CHAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= 4'd0;
         is_mem_q <= 1'b0;
         time_q   <= 16'h0;
         pc_q     <= 32'h0;
         reg_q    <= 5'd0;
         addr_q   <= 32'h0;
         data_q   <= 32'h0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         is_mem_q <= is_mem_d;
         time_q   <= time_d;
         pc_q     <= pc_d;
         reg_q    <= reg_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

endmodule

// File: tb/tb_cpu_log_emitter.sv
// Scoreboard bench for cpu_log_emitter: a lower-case/zero-idle instance and an
// upper-case/'.'-idle instance share stimulus; a negedge monitor pops expected chars.
module tb_cpu_log_emitter;
   import cpu_log_emitter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_is_mem;
   logic [15:0] in_time;
   logic [31:0] in_pc;
   logic [4:0]  in_reg;
   logic [31:0] in_addr;
   logic [31:0] in_data;

   logic        lo_ready, up_ready, in_ready;
   logic [7:0]  lo_char, up_char;
   logic        lo_valid, up_valid, lo_busy, up_busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[2][$];
   logic [7:0] mc[2];
   logic       mv[2];
   logic       mb[2];
   logic [7:0] idle_exp[2];
   string      nm[2];

   always #5 clk = ~clk;

   assign in_ready = lo_ready;
   assign mc[0] = lo_char;  assign mc[1] = up_char;
   assign mv[0] = lo_valid; assign mv[1] = up_valid;
   assign mb[0] = lo_busy;  assign mb[1] = up_busy;

   cpu_log_emitter #(.HEX_UPPER(1'b0), .IDLE_CHAR(8'h00)) dut_lo (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(lo_ready),
      .in_is_mem(in_is_mem), .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg),
      .in_addr(in_addr), .in_data(in_data),
      .char_out(lo_char), .char_valid(lo_valid), .busy(lo_busy)
   );

   cpu_log_emitter #(.HEX_UPPER(1'b1), .IDLE_CHAR(8'h2E)) dut_up (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(up_ready),
      .in_is_mem(in_is_mem), .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg),
      .in_addr(in_addr), .in_data(in_data),
      .char_out(up_char), .char_valid(up_valid), .busy(up_busy)
   );

   initial begin
      idle_exp[0] = 8'h00; idle_exp[1] = 8'h2E;
      nm[0] = "lo"; nm[1] = "up";
   end

   // Monitor: every negedge out of reset, compare each instance against its queue.
   always @(negedge clk) begin
      logic [7:0] e;
      if (reset === 1'b1) begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (mv[k]) begin
               if (exp_q[k].size() == 0) begin
                  errors++;
                  $display("FAIL %s unexpected_char: got %h, required no char", nm[k], mc[k]);
               end else begin
                  e = exp_q[k].pop_front();
                  if (mc[k] !== e) begin
                     errors++;
                     $display("FAIL %s char: got '%c' (%h), required '%c' (%h)", nm[k], mc[k], mc[k], e, e);
                  end
               end
            end else if (exp_q[k].size() != 0) begin
               errors++;
               $display("FAIL %s gap: char_valid=0, required 1 (%0d chars pending)", nm[k], exp_q[k].size());
            end else if (mc[k] !== idle_exp[k]) begin
               errors++;
               $display("FAIL %s idle_char: got %h, required %h", nm[k], mc[k], idle_exp[k]);
            end
            checks++;
            if (mb[k] !== mv[k]) begin
               errors++;
               $display("FAIL %s busy: got %b, required %b", nm[k], mb[k], mv[k]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_lo_char"},  {24'h0, lo_char}, 32'h00);
      check({tag, "_lo_valid"}, {31'h0, lo_valid}, 32'h0);
      check({tag, "_lo_busy"},  {31'h0, lo_busy},  32'h0);
      check({tag, "_lo_ready"}, {31'h0, lo_ready}, 32'h0);
      check({tag, "_up_char"},  {24'h0, up_char}, 32'h2E);
      check({tag, "_up_valid"}, {31'h0, up_valid}, 32'h0);
      check({tag, "_up_ready"}, {31'h0, up_ready}, 32'h0);
   endtask

   task automatic send(input logic m, input logic [15:0] t, input logic [31:0] pc,
                       input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
                       input string exp_s);
      string up_s;
      int    w;
      up_s = exp_s.toupper();
      @(negedge clk);
      in_valid = 1'b1; in_is_mem = m; in_time = t; in_pc = pc;
      in_reg = r; in_addr = a; in_data = d;
      w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, w);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         for (int i = 0; i < exp_s.len(); i++) begin
            exp_q[0].push_back(exp_s[i]);
            exp_q[1].push_back(up_s[i]);
         end
         $display("send %s", exp_s);
      end
   endtask

   task automatic idle_in();
      @(negedge clk);
      in_valid  = 1'b0;
      in_is_mem = 1'($urandom);
      in_time   = 16'($urandom);
      in_pc     = $urandom;
      in_reg    = 5'($urandom);
      in_addr   = $urandom;
      in_data   = $urandom;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && w < 500) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d/%0d chars pending, required 0", exp_q[0].size(), exp_q[1].size());
         exp_q[0].delete();
         exp_q[1].delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_is_mem = 1'b0; in_time = '0;
      in_pc = '0; in_reg = '0; in_addr = '0; in_data = '0;
      #1;
      check_quiet("reset");
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1 check("ready_after_reset", {31'h0, in_ready}, 32'h1);

      send(1'b1, 16'h0338, 32'h0000_3130, 5'd0,  32'h0000_0088, 32'h0fff_b528,
           "^338@00003130: *00000088 <= 0fffb528#");
      idle_in(); wait_drain();
      send(1'b0, 16'h0012, 32'h0000_3000, 5'd5,  32'h0,         32'h0000_002a,
           "^12@00003000: $5 <= 0000002a#");
      idle_in(); wait_drain();
      send(1'b0, 16'h1234, 32'h0000_0004, 5'd31, 32'h1,         32'h1234_5678,
           "^1234@00000004: $31 <= 12345678#");
      idle_in(); wait_drain();
      send(1'b0, 16'h0000, 32'h0040_0000, 5'd0,  32'h2,         32'hffff_ffff,
           "^0@00400000: $0 <= ffffffff#");
      idle_in(); wait_drain();
      send(1'b0, 16'h0A05, 32'hdead_beef, 5'd10, 32'h3,         32'hdead_beef,
           "^?05@deadbeef: $10 <= deadbeef#");
      idle_in(); wait_drain();

      // Back-to-back with in_valid held high.
      send(1'b1, 16'h0100, 32'h0000_abcd, 5'd7,  32'hffff_0000, 32'h0000_0000,
           "^100@0000abcd: *ffff0000 <= 00000000#");
      send(1'b0, 16'h9999, 32'h0000_1000, 5'd25, 32'h4,         32'h00c0_ffee,
           "^9999@00001000: $25 <= 00c0ffee#");
      idle_in(); wait_drain();

      // Asynchronous reset in the middle of the PC field.
      send(1'b1, 16'h0338, 32'h0000_3130, 5'd0,  32'h0000_0088, 32'h0fff_b528,
           "^338@00003130: *00000088 <= 0fffb528#");
      idle_in();
      repeat (6) @(posedge clk);
      #2 reset = 1'b0;
      #1 check_quiet("midrec_reset");
      exp_q[0].delete();
      exp_q[1].delete();
      @(negedge clk);
      #1 reset = 1'b1;
      #1 check("ready_after_midrec_reset", {31'h0, in_ready}, 32'h1);
      send(1'b1, 16'h0338, 32'h0000_3130, 5'd0,  32'h0000_0088, 32'h0fff_b528,
           "^338@00003130: *00000088 <= 0fffb528#");
      idle_in(); wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
